// File: rtl/wb_gpio_arb.sv
// Two-master Wishbone arbiter in front of a single wb_gpio slave.
// Round-robin grant held for a whole bus cycle, with a stall timeout that aborts the owner.
module wb_gpio_arb #(
    parameter int wb_dat_width = 32,
    parameter int wb_adr_width = 32,
    parameter int TIMEOUT      = 16
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic [wb_adr_width-1:0] m0_adr_i,
    input  logic [wb_dat_width-1:0] m0_dat_i,
    input  logic                    m0_we_i,
    input  logic                    m0_cyc_i,
    input  logic                    m0_stb_i,
    output logic                    m0_ack_o,
    output logic                    m0_err_o,
    output logic [wb_dat_width-1:0] m0_dat_o,

    input  logic [wb_adr_width-1:0] m1_adr_i,
    input  logic [wb_dat_width-1:0] m1_dat_i,
    input  logic                    m1_we_i,
    input  logic                    m1_cyc_i,
    input  logic                    m1_stb_i,
    output logic                    m1_ack_o,
    output logic                    m1_err_o,
    output logic [wb_dat_width-1:0] m1_dat_o,

    output logic [wb_adr_width-1:0] s_adr_o,
    output logic [wb_dat_width-1:0] s_dat_o,
    output logic                    s_we_o,
    output logic                    s_cyc_o,
    output logic                    s_stb_o,
    input  logic                    s_ack_i,
    input  logic [wb_dat_width-1:0] s_dat_i,

    output logic [1:0]              gnt_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT0  = 2'd1,
        GNT1  = 2'd2,
        ABORT = 2'd3
    } state_e;

    localparam bit         TO_EN   = (TIMEOUT != 0);
    localparam logic [7:0] TO_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

    state_e     state_q, state_d;
    logic       last_q, last_d;
    logic       abrt_q, abrt_d;
    logic [7:0] tcnt_q, tcnt_d;

    logic                    own;
    logic                    cur_cyc;
    logic                    cur_stb;
    logic                    cur_we;
    logic [wb_adr_width-1:0] cur_adr;
    logic [wb_dat_width-1:0] cur_dat;
    logic                    other_cyc;
    logic                    timeout_hit;

    assign own = (state_q == GNT1);

    always_comb begin
        cur_cyc   = own ? m1_cyc_i : m0_cyc_i;
        cur_stb   = own ? m1_stb_i : m0_stb_i;
        cur_we    = own ? m1_we_i  : m0_we_i;
        cur_adr   = own ? m1_adr_i : m0_adr_i;
        cur_dat   = own ? m1_dat_i : m0_dat_i;
        other_cyc = own ? m0_cyc_i : m1_cyc_i;
    end

    // Slave-side and master-side routing is purely a function of the current owner.
    always_comb begin
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_we_o   = 1'b0;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m0_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        m1_dat_o = '0;
        gnt_o    = 2'b00;
        case (state_q)
            GNT0, GNT1: begin
                s_adr_o = cur_adr;
                s_dat_o = cur_dat;
                s_we_o  = cur_we;
                s_cyc_o = cur_cyc;
                s_stb_o = cur_stb & cur_cyc;
                if (own) begin
                    m1_ack_o = s_ack_i;
                    m1_dat_o = s_dat_i;
                    gnt_o    = 2'b10;
                end else begin
                    m0_ack_o = s_ack_i;
                    m0_dat_o = s_dat_i;
                    gnt_o    = 2'b01;
                end
            end
            ABORT: begin
                if (abrt_q) begin
                    m1_err_o = 1'b1;
                end else begin
                    m0_err_o = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    assign timeout_hit = TO_EN && s_stb_o && !s_ack_i && (tcnt_q == TO_LAST);

    // An ack in the terminal stall cycle beats the timeout because it is tested first.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        abrt_d  = abrt_q;
        tcnt_d  = '0;
        case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = last_q ? GNT0 : GNT1;
                end else if (m0_cyc_i) begin
                    state_d = GNT0;
                end else if (m1_cyc_i) begin
                    state_d = GNT1;
                end
            end
            GNT0, GNT1: begin
                if (!cur_cyc) begin
                    last_d = own;
                    if (other_cyc) begin
                        state_d = own ? GNT0 : GNT1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (s_ack_i) begin
                    tcnt_d = '0;
                end else if (timeout_hit) begin
                    state_d = ABORT;
                    abrt_d  = own;
                end else if (s_stb_o) begin
                    tcnt_d = (tcnt_q == 8'hFF) ? tcnt_q : tcnt_q + 8'd1;
                end else begin
                    tcnt_d = tcnt_q;
                end
            end
            ABORT: begin
                last_d  = abrt_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset leaves last pointing at m1 so m0 wins the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            abrt_q  <= 1'b0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            abrt_q  <= abrt_d;
            tcnt_q  <= tcnt_d;
        end
    end

endmodule

// File: tb/tb_wb_gpio_arb.sv
// Directed bench for wb_gpio_arb: one instance with TIMEOUT=8, one with the timeout disabled.
module tb_wb_gpio_arb;

    logic        clk;
    logic        rst;
    logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i, s_dat_i;
    logic        m0_we_i, m0_cyc_i, m0_stb_i, m1_we_i, m1_cyc_i, m1_stb_i, s_ack_i;

    logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
    logic        s_we_o, s_cyc_o, s_stb_o;
    logic [1:0]  gnt_o;

    logic        d2M0Ack, d2M0Err, d2M1Ack, d2M1Err;
    logic [31:0] d2M0Dat, d2M1Dat, d2SAdr, d2SDat;
    logic        d2SWe, d2SCyc, d2SStb;
    logic [1:0]  d2Gnt;

    int passed = 0;
    int total  = 0;

    wb_gpio_arb #(.wb_dat_width(32), .wb_adr_width(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_we_i(m0_we_i), .m0_cyc_i(m0_cyc_i),
        .m0_stb_i(m0_stb_i), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_dat_o(m0_dat_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_we_i(m1_we_i), .m1_cyc_i(m1_cyc_i),
        .m1_stb_i(m1_stb_i), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_dat_o(m1_dat_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_cyc_o(s_cyc_o),
        .s_stb_o(s_stb_o), .s_ack_i(s_ack_i), .s_dat_i(s_dat_i), .gnt_o(gnt_o)
    );

    wb_gpio_arb #(.wb_dat_width(32), .wb_adr_width(32), .TIMEOUT(0)) dutNoTo (
        .clk(clk), .rst(rst),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_we_i(m0_we_i), .m0_cyc_i(m0_cyc_i),
        .m0_stb_i(m0_stb_i), .m0_ack_o(d2M0Ack), .m0_err_o(d2M0Err), .m0_dat_o(d2M0Dat),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_we_i(m1_we_i), .m1_cyc_i(m1_cyc_i),
        .m1_stb_i(m1_stb_i), .m1_ack_o(d2M1Ack), .m1_err_o(d2M1Err), .m1_dat_o(d2M1Dat),
        .s_adr_o(d2SAdr), .s_dat_o(d2SDat), .s_we_o(d2SWe), .s_cyc_o(d2SCyc),
        .s_stb_o(d2SStb), .s_ack_i(s_ack_i), .s_dat_i(s_dat_i), .gnt_o(d2Gnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clearInputs();
        m0_adr_i = '0; m0_dat_i = '0; m0_we_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        m1_adr_i = '0; m1_dat_i = '0; m1_we_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        s_ack_i  = 1'b0; s_dat_i = '0;
    endtask

    task automatic do_reset();
        clearInputs();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        clearInputs();
        rst = 1'b0;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h44; s_ack_i = 1'b1; s_dat_i = 32'hFF;
        tick();
        tick();
        total++; if (gnt_o !== 2'b00) $display("[TB] FAIL rst_gnt: got %b expected 00", gnt_o); else passed++;
        total++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) $display("[TB] FAIL rst_cyc_stb: got %b%b expected 00", s_cyc_o, s_stb_o); else passed++;
        total++; if (m0_ack_o !== 1'b0 || m0_dat_o !== 32'h0 || s_adr_o !== 32'h0) $display("[TB] FAIL rst_route: ack %b dat %h adr %h expected 0", m0_ack_o, m0_dat_o, s_adr_o); else passed++;
        clearInputs();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        do_reset();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b0; m0_adr_i = 32'h0;
        settle();
        total++; if (gnt_o !== 2'b00) $display("[TB] FAIL t1_latency: got %b expected 00", gnt_o); else passed++;
        tick();
        total++; if (gnt_o !== 2'b01 || s_stb_o !== 1'b1) $display("[TB] FAIL t1_gnt: gnt %b stb %b expected 01 1", gnt_o, s_stb_o); else passed++;
        s_ack_i = 1'b1; s_dat_i = 32'h0000_00A5;
        settle();
        total++; if (m0_ack_o !== 1'b1 || m0_dat_o !== 32'h0000_00A5) $display("[TB] FAIL t1_ack: ack %b dat %h expected 1 000000a5", m0_ack_o, m0_dat_o); else passed++;
        total++; if (m1_ack_o !== 1'b0 || m1_dat_o !== 32'h0) $display("[TB] FAIL t1_m1_quiet: ack %b dat %h expected 0 0", m1_ack_o, m1_dat_o); else passed++;
        tick();
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; s_ack_i = 1'b0;
        tick();
        s_ack_i = 1'b1;
        settle();
        total++; if (m0_ack_o !== 1'b0 || gnt_o !== 2'b00) $display("[TB] FAIL t1_idle_ack: ack %b gnt %b expected 0 00", m0_ack_o, gnt_o); else passed++;
        s_ack_i = 1'b0;
    endtask

    task automatic test_round_robin();
        do_reset();
        m0_cyc_i = 1'b1; m1_cyc_i = 1'b1;
        tick();
        total++; if (gnt_o !== 2'b01) $display("[TB] FAIL t2_first_tie: got %b expected 01", gnt_o); else passed++;
        tick();
        m0_cyc_i = 1'b0;
        tick();
        total++; if (gnt_o !== 2'b10) $display("[TB] FAIL t2_handover: got %b expected 10", gnt_o); else passed++;
        m1_cyc_i = 1'b0;
        tick();
        total++; if (gnt_o !== 2'b00) $display("[TB] FAIL t2_idle: got %b expected 00", gnt_o); else passed++;
        m0_cyc_i = 1'b1; m1_cyc_i = 1'b1;
        tick();
        total++; if (gnt_o !== 2'b01) $display("[TB] FAIL t2_second_tie: got %b expected 01", gnt_o); else passed++;
        m0_cyc_i = 1'b0; m1_cyc_i = 1'b0;
        tick();
        m0_cyc_i = 1'b1; m1_cyc_i = 1'b1;
        tick();
        total++; if (gnt_o !== 2'b10) $display("[TB] FAIL t2_third_tie: got %b expected 10", gnt_o); else passed++;
        clearInputs();
        tick();
    endtask

    task automatic test_timeout();
        logic earlyErr;
        do_reset();
        earlyErr = 1'b0;
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b1; m1_adr_i = 32'h10; m1_dat_i = 32'h55;
        tick();
        total++; if (gnt_o !== 2'b10 || s_we_o !== 1'b1 || s_dat_o !== 32'h55) $display("[TB] FAIL t3_route: gnt %b we %b dat %h expected 10 1 00000055", gnt_o, s_we_o, s_dat_o); else passed++;
        for (int i = 2; i <= 8; i++) begin
            tick();
            if (m1_err_o !== 1'b0 || s_cyc_o !== 1'b1) earlyErr = 1'b1;
        end
        total++; if (earlyErr !== 1'b0) $display("[TB] FAIL t3_early_abort: got %b expected 0", earlyErr); else passed++;
        tick();
        s_ack_i = 1'b1;
        settle();
        total++; if (m1_err_o !== 1'b1 || s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) $display("[TB] FAIL t3_abort: err %b cyc %b stb %b expected 1 0 0", m1_err_o, s_cyc_o, s_stb_o); else passed++;
        total++; if (gnt_o !== 2'b00 || m1_ack_o !== 1'b0 || m0_err_o !== 1'b0) $display("[TB] FAIL t3_abort_side: gnt %b ack %b m0err %b expected 00 0 0", gnt_o, m1_ack_o, m0_err_o); else passed++;
        clearInputs();
        tick();
        total++; if (m1_err_o !== 1'b0 || gnt_o !== 2'b00) $display("[TB] FAIL t3_after: err %b gnt %b expected 0 00", m1_err_o, gnt_o); else passed++;
    endtask

    task automatic test_ack_at_terminal();
        do_reset();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h8;
        tick();
        for (int i = 2; i <= 7; i++) tick();
        tick();
        s_ack_i = 1'b1; s_dat_i = 32'h1234;
        settle();
        total++; if (m0_ack_o !== 1'b1 || m0_err_o !== 1'b0) $display("[TB] FAIL t3b_ack: ack %b err %b expected 1 0", m0_ack_o, m0_err_o); else passed++;
        tick();
        s_ack_i = 1'b0;
        settle();
        total++; if (m0_err_o !== 1'b0 || gnt_o !== 2'b01) $display("[TB] FAIL t3b_no_err: err %b gnt %b expected 0 01", m0_err_o, gnt_o); else passed++;
        clearInputs();
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] adrs [3];
        adrs[0] = 32'h4; adrs[1] = 32'h8; adrs[2] = 32'hC;
        do_reset();
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 32'h20; m1_we_i = 1'b0;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b1; m0_adr_i = adrs[0]; m0_dat_i = 32'h1;
        tick();
        s_ack_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            m0_adr_i = adrs[i];
            m0_dat_i = 32'(i + 1);
            settle();
            total++; if (gnt_o !== 2'b01 || s_adr_o !== adrs[i] || m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0) $display("[TB] FAIL t4_write%0d: gnt %b adr %h ack %b/%b expected 01 %h 1/0", i, gnt_o, s_adr_o, m0_ack_o, m1_ack_o, adrs[i]); else passed++;
            tick();
        end
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; s_ack_i = 1'b0;
        settle();
        total++; if (gnt_o !== 2'b01) $display("[TB] FAIL t4_hold_release_cycle: got %b expected 01", gnt_o); else passed++;
        tick();
        total++; if (gnt_o !== 2'b10 || s_adr_o !== 32'h20 || s_we_o !== 1'b0) $display("[TB] FAIL t4_m1_gnt: gnt %b adr %h we %b expected 10 00000020 0", gnt_o, s_adr_o, s_we_o); else passed++;
        clearInputs();
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 32'h30;
        tick();
        s_ack_i = 1'b1;
        settle();
        total++; if (gnt_o !== 2'b10 || m1_ack_o !== 1'b1) $display("[TB] FAIL t5_pre: gnt %b ack %b expected 10 1", gnt_o, m1_ack_o); else passed++;
        #2;
        rst = 1'b0;
        #1;
        total++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || gnt_o !== 2'b00 || m1_ack_o !== 1'b0) $display("[TB] FAIL t5_async: cyc %b stb %b gnt %b ack %b expected 0 0 00 0", s_cyc_o, s_stb_o, gnt_o, m1_ack_o); else passed++;
        tick();
        s_ack_i = 1'b0;
        m0_cyc_i = 1'b1;
        rst = 1'b1;
        tick();
        total++; if (gnt_o !== 2'b01) $display("[TB] FAIL t5_tie: got %b expected 01", gnt_o); else passed++;
        clearInputs();
        tick();
    endtask

    task automatic test_no_timeout();
        logic sawErr;
        do_reset();
        sawErr = 1'b0;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h0;
        tick();
        for (int i = 0; i < 300; i++) begin
            if (d2M0Err !== 1'b0 || d2Gnt !== 2'b01) sawErr = 1'b1;
            tick();
        end
        total++; if (sawErr !== 1'b0) $display("[TB] FAIL t6_stall: got %b expected 0", sawErr); else passed++;
        s_ack_i = 1'b1; s_dat_i = 32'hBEEF;
        settle();
        total++; if (d2M0Ack !== 1'b1 || d2M0Err !== 1'b0 || d2M0Dat !== 32'hBEEF) $display("[TB] FAIL t6_ack: ack %b err %b dat %h expected 1 0 0000beef", d2M0Ack, d2M0Err, d2M0Dat); else passed++;
        clearInputs();
        tick();
        tick();
    endtask

    initial begin
        rst = 1'b0;
        clearInputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_timeout();
        test_ack_at_terminal();
        test_back_to_back();
        test_async_reset();
        test_no_timeout();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
